// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand stage: ALU control codes, ALUOp values
// and R-type funct fields.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_SLT = 4'b1001;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_ANDI  = 3'b011;
    localparam logic [2:0] OP_ORI   = 3'b100;
    localparam logic [2:0] OP_SLTI  = 3'b101;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    function automatic logic is_shift_op(input logic [2:0] aluop, input logic [5:0] funct);
        return (aluop == OP_RTYPE) && (funct == F_SLL || funct == F_SRL || funct == F_SRA);
    endfunction

    function automatic logic is_zext_op(input logic [2:0] aluop);
        return (aluop == OP_ANDI) || (aluop == OP_ORI);
    endfunction

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALUOp/funct to ALU control decode, flagging unsupported codes.
module alu_control_decode
    import alu_pkg::*;
(
    input  logic [2:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [3:0] ALUCtrl,
    output logic       Illegal
);

    always_comb begin
        ALUCtrl = ALU_ADD;
        Illegal = 1'b0;
        case (ALUOp)
            OP_ADD:  ALUCtrl = ALU_ADD;
            OP_SUB:  ALUCtrl = ALU_SUB;
            OP_ANDI: ALUCtrl = ALU_AND;
            OP_ORI:  ALUCtrl = ALU_OR;
            OP_SLTI: ALUCtrl = ALU_SLT;
            OP_RTYPE: begin
                case (Funct)
                    F_ADD, F_ADDU: ALUCtrl = ALU_ADD;
                    F_SUB:         ALUCtrl = ALU_SUB;
                    F_AND:         ALUCtrl = ALU_AND;
                    F_OR:          ALUCtrl = ALU_OR;
                    F_SLT:         ALUCtrl = ALU_SLT;
                    F_SLL:         ALUCtrl = ALU_SLL;
                    F_SRL:         ALUCtrl = ALU_SRL;
                    F_SRA:         ALUCtrl = ALU_SRA;
                    default: begin
                        ALUCtrl = ALU_AND;
                        Illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                ALUCtrl = ALU_ADD;
                Illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ID/EX stage feeding the ALU: valid/ready handshake, forwarding,
// immediate extension and shift-amount routing.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            InValid,
    output logic            InReady,
    input  logic            Flush,
    input  logic [2:0]      ALUOp,
    input  logic [5:0]      Funct,
    input  logic            ALUSrc,
    input  logic [15:0]     Imm16,
    input  logic [4:0]      Shamt,
    input  logic [4:0]      RsAddr,
    input  logic [4:0]      RtAddr,
    input  logic [4:0]      DestAddr,
    input  logic [XLEN-1:0] RsData,
    input  logic [XLEN-1:0] RtData,
    input  logic            FwdMemWe,
    input  logic [4:0]      FwdMemAddr,
    input  logic [XLEN-1:0] FwdMemData,
    input  logic            FwdWbWe,
    input  logic [4:0]      FwdWbAddr,
    input  logic [XLEN-1:0] FwdWbData,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] MuxOutA,
    output logic [XLEN-1:0] MuxOutB,
    output logic [3:0]      ALUCtrlOut,
    output logic [4:0]      DestAddrOut,
    output logic            IllegalOp
);

    logic            out_valid;
    logic [4:0]      rs_addr_q, rt_addr_q, dest_q, shamt_q;
    logic [XLEN-1:0] rs_data_q, rt_data_q, imm_q;
    logic            alusrc_q, shift_q, illegal_q;
    logic [3:0]      ctrl_q;

    logic [3:0]      dec_ctrl;
    logic            dec_illegal;
    logic            accept;
    logic [XLEN-1:0] imm_ext, fwd_rs, fwd_rt;

    alu_control_decode u_dec (
        .ALUOp   (ALUOp),
        .Funct   (Funct),
        .ALUCtrl (dec_ctrl),
        .Illegal (dec_illegal)
    );

    // MEM result is younger than WB, so it takes priority; r0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] data,
        input logic            mem_we,
        input logic [4:0]      mem_addr,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_we,
        input logic [4:0]      wb_addr,
        input logic [XLEN-1:0] wb_data
    );
        if (addr != 5'd0 && mem_we && mem_addr == addr) return mem_data;
        if (addr != 5'd0 && wb_we && wb_addr == addr)   return wb_data;
        return data;
    endfunction

    always_comb begin
        fwd_rs = fwd(rs_addr_q, rs_data_q, FwdMemWe, FwdMemAddr, FwdMemData,
                     FwdWbWe, FwdWbAddr, FwdWbData);
        fwd_rt = fwd(rt_addr_q, rt_data_q, FwdMemWe, FwdMemAddr, FwdMemData,
                     FwdWbWe, FwdWbAddr, FwdWbData);
        imm_ext = is_zext_op(ALUOp) ? {{(XLEN-16){1'b0}}, Imm16}
                                    : {{(XLEN-16){Imm16[15]}}, Imm16};
    end

    assign InReady = !out_valid | OutReady;
    assign accept  = InValid & InReady;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            dest_q    <= '0;
            shamt_q   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alusrc_q  <= 1'b0;
            shift_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else if (Flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rs_addr_q <= RsAddr;
            rt_addr_q <= RtAddr;
            dest_q    <= DestAddr;
            shamt_q   <= Shamt;
            rs_data_q <= RsData;
            rt_data_q <= RtData;
            imm_q     <= imm_ext;
            alusrc_q  <= ALUSrc;
            shift_q   <= is_shift_op(ALUOp, Funct);
            illegal_q <= dec_illegal;
            ctrl_q    <= dec_ctrl;
        end else if (OutReady) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            // Stalled: absorb results retiring now so they survive the stall.
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end
    end

    assign OutValid    = out_valid;
    assign MuxOutA     = shift_q ? {{(XLEN-5){1'b0}}, shamt_q} : fwd_rs;
    assign MuxOutB     = alusrc_q ? imm_q : fwd_rt;
    assign ALUCtrlOut  = ctrl_q;
    assign DestAddrOut = dest_q;
    assign IllegalOp   = illegal_q & out_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: fixed vectors, hand sequences
// and randomized traffic compared against a field-level reference model.
module tb_alu_operand_stage;

    logic        Clock;
    logic        Reset_n, InValid, InReady, Flush, ALUSrc, OutValid, OutReady, IllegalOp;
    logic [2:0]  ALUOp;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic [4:0]  Shamt, RsAddr, RtAddr, DestAddr, FwdMemAddr, FwdWbAddr, DestAddrOut;
    logic [31:0] RsData, RtData, FwdMemData, FwdWbData, MuxOutA, MuxOutB;
    logic        FwdMemWe, FwdWbWe;
    logic [3:0]  ALUCtrlOut;

    alu_operand_stage #(.XLEN(32)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .Flush(Flush), .ALUOp(ALUOp), .Funct(Funct), .ALUSrc(ALUSrc), .Imm16(Imm16),
        .Shamt(Shamt), .RsAddr(RsAddr), .RtAddr(RtAddr), .DestAddr(DestAddr),
        .RsData(RsData), .RtData(RtData), .FwdMemWe(FwdMemWe), .FwdMemAddr(FwdMemAddr),
        .FwdMemData(FwdMemData), .FwdWbWe(FwdWbWe), .FwdWbAddr(FwdWbAddr),
        .FwdWbData(FwdWbData), .OutValid(OutValid), .OutReady(OutReady),
        .MuxOutA(MuxOutA), .MuxOutB(MuxOutB), .ALUCtrlOut(ALUCtrlOut),
        .DestAddrOut(DestAddrOut), .IllegalOp(IllegalOp)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Reference model: the raw fields of the held instruction.
    logic        m_known = 1'b0;
    logic        m_valid, m_fresh, m_alusrc;
    logic [2:0]  m_aluop;
    logic [5:0]  m_funct;
    logic [15:0] m_imm;
    logic [4:0]  m_shamt, m_rs, m_rt, m_dest;
    logic [31:0] m_rsd, m_rtd;

    typedef struct {
        logic [2:0]  aluop;
        logic [5:0]  funct;
        logic        alusrc;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  ec;
        logic        ei;
    } vec_t;

    vec_t vecs[15];
    logic [5:0] flist[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] d);
        if (a != 0 && FwdMemWe && FwdMemAddr == a) return FwdMemData;
        if (a != 0 && FwdWbWe && FwdWbAddr == a) return FwdWbData;
        return d;
    endfunction

    function automatic logic [3:0] m_ctrl(input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'd0: return 4'b0001;
            3'd1: return 4'b0010;
            3'd3: return 4'b0000;
            3'd4: return 4'b0011;
            3'd5: return 4'b1001;
            3'd2: case (f)
                6'h20, 6'h21: return 4'b0001;
                6'h22: return 4'b0010;
                6'h24: return 4'b0000;
                6'h25: return 4'b0011;
                6'h2A: return 4'b1001;
                6'h00: return 4'b0101;
                6'h02: return 4'b0110;
                6'h03: return 4'b1000;
                default: return 4'b0000;
            endcase
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic m_ill(input logic [2:0] op, input logic [5:0] f);
        if (op == 3'd6 || op == 3'd7) return 1'b1;
        if (op != 3'd2) return 1'b0;
        return !(f inside {6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03});
    endfunction

    function automatic logic [31:0] m_a();
        if (m_aluop == 3'd2 && m_funct inside {6'h00, 6'h02, 6'h03}) return {27'd0, m_shamt};
        return m_fwd(m_rs, m_rsd);
    endfunction

    function automatic logic [31:0] m_b();
        if (!m_alusrc) return m_fwd(m_rt, m_rtd);
        if (m_aluop == 3'd3 || m_aluop == 3'd4) return {16'd0, m_imm};
        return {{16{m_imm[15]}}, m_imm};
    endfunction

    task automatic settle();
        #1;
    endtask

    task automatic model_compare();
        if (m_known) begin
            chk("InReady", {31'd0, InReady}, {31'd0, !m_valid | OutReady});
            chk("OutValid", {31'd0, OutValid}, {31'd0, m_valid});
            chk("IllegalOp", {31'd0, IllegalOp}, {31'd0, m_valid & m_ill(m_aluop, m_funct)});
            if (m_valid || m_fresh) begin
                chk("MuxOutA", MuxOutA, m_a());
                chk("MuxOutB", MuxOutB, m_b());
                chk("ALUCtrlOut", {28'd0, ALUCtrlOut}, {28'd0, m_fresh ? 4'b0000 : m_ctrl(m_aluop, m_funct)});
                chk("DestAddrOut", {27'd0, DestAddrOut}, {27'd0, m_dest});
            end
        end
    endtask

    // One clock: check current outputs, then advance the model on the edge.
    task automatic cyc();
        logic rdy;
        logic [31:0] nrs, nrt;
        settle();
        model_compare();
        @(posedge Clock);
        rdy = !m_valid | OutReady;
        if (!Reset_n) begin
            m_known = 1; m_valid = 0; m_fresh = 1; m_alusrc = 0; m_aluop = 0; m_funct = 0;
            m_imm = 0; m_shamt = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_rsd = 0; m_rtd = 0;
        end else if (m_known) begin
            if (Flush) m_valid = 0;
            else if (InValid && rdy) begin
                m_valid = 1; m_fresh = 0; m_alusrc = ALUSrc; m_aluop = ALUOp; m_funct = Funct;
                m_imm = Imm16; m_shamt = Shamt; m_rs = RsAddr; m_rt = RtAddr; m_dest = DestAddr;
                m_rsd = RsData; m_rtd = RtData;
            end else if (OutReady) m_valid = 0;
            else if (m_valid) begin
                nrs = m_fwd(m_rs, m_rsd);
                nrt = m_fwd(m_rt, m_rtd);
                m_rsd = nrs;
                m_rtd = nrt;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic src,
                         input logic [15:0] imm, input logic [4:0] sh, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dst,
                         input logic [31:0] rsd, input logic [31:0] rtd);
        InValid = 1; ALUOp = op; Funct = f; ALUSrc = src; Imm16 = imm; Shamt = sh;
        RsAddr = rs; RtAddr = rt; DestAddr = dst; RsData = rsd; RtData = rtd;
    endtask

    task automatic bus_idle();
        FwdMemWe = 0; FwdMemAddr = 0; FwdMemData = 0;
        FwdWbWe = 0; FwdWbAddr = 0; FwdWbData = 0;
    endtask

    initial begin
        vecs[0]  = '{3'd3, 6'h00, 1'b1, 16'h8001, 5'd0,  32'h1,    32'h2,        32'h1,    32'h00008001, 4'b0000, 1'b0};
        vecs[1]  = '{3'd0, 6'h00, 1'b1, 16'h8001, 5'd0,  32'h10,   32'h2,        32'h10,   32'hFFFF8001, 4'b0001, 1'b0};
        vecs[2]  = '{3'd4, 6'h00, 1'b1, 16'hF0F0, 5'd0,  32'h3,    32'h2,        32'h3,    32'h0000F0F0, 4'b0011, 1'b0};
        vecs[3]  = '{3'd5, 6'h00, 1'b1, 16'hFFFE, 5'd0,  32'h4,    32'h2,        32'h4,    32'hFFFFFFFE, 4'b1001, 1'b0};
        vecs[4]  = '{3'd2, 6'h03, 1'b0, 16'h0000, 5'd31, 32'hDEAD, 32'h80000000, 32'd31,   32'h80000000, 4'b1000, 1'b0};
        vecs[5]  = '{3'd2, 6'h00, 1'b0, 16'h0000, 5'd4,  32'h9,    32'h1,        32'd4,    32'h1,        4'b0101, 1'b0};
        vecs[6]  = '{3'd2, 6'h02, 1'b0, 16'h0000, 5'd0,  32'h9,    32'h5,        32'd0,    32'h5,        4'b0110, 1'b0};
        vecs[7]  = '{3'd2, 6'h2A, 1'b0, 16'h0000, 5'd3,  32'h7,    32'h9,        32'h7,    32'h9,        4'b1001, 1'b0};
        vecs[8]  = '{3'd2, 6'h24, 1'b0, 16'h0000, 5'd0,  32'hA,    32'hB,        32'hA,    32'hB,        4'b0000, 1'b0};
        vecs[9]  = '{3'd2, 6'h25, 1'b0, 16'h0000, 5'd0,  32'hC,    32'hD,        32'hC,    32'hD,        4'b0011, 1'b0};
        vecs[10] = '{3'd2, 6'h21, 1'b0, 16'h0000, 5'd0,  32'hE,    32'hF,        32'hE,    32'hF,        4'b0001, 1'b0};
        vecs[11] = '{3'd2, 6'h22, 1'b0, 16'h0000, 5'd0,  32'h11,   32'h12,       32'h11,   32'h12,       4'b0010, 1'b0};
        vecs[12] = '{3'd2, 6'h18, 1'b0, 16'h0000, 5'd0,  32'h13,   32'h14,       32'h13,   32'h14,       4'b0000, 1'b1};
        vecs[13] = '{3'd6, 6'h00, 1'b1, 16'h0004, 5'd0,  32'h15,   32'h16,       32'h15,   32'h4,        4'b0001, 1'b1};
        vecs[14] = '{3'd1, 6'h00, 1'b0, 16'h0000, 5'd0,  32'h17,   32'h18,       32'h17,   32'h18,       4'b0010, 1'b0};
        flist = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h18};

        // Reset with an instruction offered
        Reset_n = 0; Flush = 0; OutReady = 1; bus_idle();
        drive(3'd2, 6'h18, 1'b1, 16'hFFFF, 5'd9, 5'd3, 5'd4, 5'd5, 32'h55, 32'h66);
        cyc(); cyc();
        Reset_n = 1; InValid = 0;
        settle();
        chk("rst_OutValid", {31'd0, OutValid}, 32'd0);
        chk("rst_ctrl", {28'd0, ALUCtrlOut}, 32'd0);
        chk("rst_A", MuxOutA, 32'd0);
        chk("rst_B", MuxOutB, 32'd0);
        chk("rst_ill", {31'd0, IllegalOp}, 32'd0);
        cyc();

        // Back-to-back R-type add then sub
        drive(3'd2, 6'h20, 1'b0, 16'h0, 5'd0, 5'd5, 5'd7, 5'd1, 32'h100, 32'h200);
        settle(); chk("b2b_rdy0", {31'd0, InReady}, 32'd1);
        cyc();
        drive(3'd2, 6'h22, 1'b0, 16'h0, 5'd0, 5'd5, 5'd7, 5'd2, 32'h300, 32'h400);
        settle();
        chk("b2b_ctrl0", {28'd0, ALUCtrlOut}, 32'b0001);
        chk("b2b_rdy1", {31'd0, InReady}, 32'd1);
        cyc();
        InValid = 0;
        settle();
        chk("b2b_ctrl1", {28'd0, ALUCtrlOut}, 32'b0010);
        chk("b2b_valid1", {31'd0, OutValid}, 32'd1);
        cyc();

        // Forward priority, then r0 never forwards
        drive(3'd0, 6'h0, 1'b0, 16'h0, 5'd0, 5'd3, 5'd6, 5'd3, 32'h5, 32'h6);
        cyc(); InValid = 0;
        FwdMemWe = 1; FwdMemAddr = 3; FwdMemData = 32'hAAAA0000;
        FwdWbWe = 1; FwdWbAddr = 3; FwdWbData = 32'h11111111;
        settle(); chk("fwd_mem_wins", MuxOutA, 32'hAAAA0000);
        cyc();
        bus_idle();
        drive(3'd0, 6'h0, 1'b0, 16'h0, 5'd0, 5'd0, 5'd6, 5'd3, 32'hCAFE, 32'h6);
        cyc(); InValid = 0;
        FwdMemWe = 1; FwdMemAddr = 0; FwdMemData = 32'hAAAA0000;
        FwdWbWe = 1; FwdWbAddr = 0; FwdWbData = 32'h11111111;
        settle(); chk("fwd_r0", MuxOutA, 32'hCAFE);
        cyc(); bus_idle();

        // Stall refresh: WB retires Rt mid-stall
        drive(3'd2, 6'h20, 1'b0, 16'h0, 5'd0, 5'd8, 5'd9, 5'd4, 32'h1, 32'h2);
        cyc();
        InValid = 1; OutReady = 0; RtAddr = 5'd9; RtData = 32'h77;
        cyc();
        FwdWbWe = 1; FwdWbAddr = 9; FwdWbData = 32'h12345678;
        cyc();
        FwdWbAddr = 4; FwdWbData = 32'hBAD0BAD0;
        settle(); chk("stall_hold", MuxOutB, 32'h12345678);
        cyc();
        OutReady = 1; InValid = 0;
        settle(); chk("stall_release", MuxOutB, 32'h12345678);
        cyc(); bus_idle();

        // Fixed vectors
        for (int unsigned i = 0; i < 15; i++) begin
            drive(vecs[i].aluop, vecs[i].funct, vecs[i].alusrc, vecs[i].imm, vecs[i].shamt,
                  5'd1, 5'd2, 5'(i), vecs[i].rsd, vecs[i].rtd);
            cyc();
            InValid = 0;
            settle();
            chk($sformatf("vec%0d_A", i), MuxOutA, vecs[i].ea);
            chk($sformatf("vec%0d_B", i), MuxOutB, vecs[i].eb);
            chk($sformatf("vec%0d_ctrl", i), {28'd0, ALUCtrlOut}, {28'd0, vecs[i].ec});
            chk($sformatf("vec%0d_ill", i), {31'd0, IllegalOp}, {31'd0, vecs[i].ei});
            cyc();
        end

        // Flush while stalled with an incoming instruction
        drive(3'd0, 6'h0, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2);
        cyc();
        OutReady = 0; InValid = 0;
        cyc();
        Flush = 1;
        drive(3'd1, 6'h0, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd8, 32'h3, 32'h4);
        cyc();
        Flush = 0; InValid = 0;
        settle(); chk("flush_valid", {31'd0, OutValid}, 32'd0);
        cyc();
        OutReady = 1;
        cyc();

        // Randomized traffic
        for (int unsigned n = 0; n < 600; n++) begin
            Reset_n = ($urandom_range(0, 99) != 0);
            Flush = ($urandom_range(0, 19) == 0);
            OutReady = ($urandom_range(0, 9) < 7);
            drive(3'($urandom_range(0, 7)), flist[$urandom_range(0, 9)], 1'($urandom),
                  16'($urandom), 5'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom), $urandom, $urandom);
            InValid = ($urandom_range(0, 3) != 0);
            FwdMemWe = 1'($urandom); FwdMemAddr = 5'($urandom_range(0, 3)); FwdMemData = $urandom;
            FwdWbWe = 1'($urandom); FwdWbAddr = 5'($urandom_range(0, 3)); FwdWbData = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
